dcc_packet_sequencer: RTL and testbench
=======================================

Name: dcc_packet_sequencer

Overview:
- Bit-level scheduler for the DCC line encoder. Accepts whole DCC packets (address/instruction bytes) over a valid/ready handshake and computes the XOR error byte itself.
- Serialises each packet as preamble, then per-byte 0-separator plus 8 data bits MSB-first, then the end bit 1.
- Drives the encoder's next_bit input and advances one bit per encoder ack.
- Holds one packet in a skid buffer so consecutive packets go out back-to-back.

Parameters:
- MAX_BYTES, 5, max data bytes per packet excluding the error byte (2..6).
- PREAMBLE_BITS, 14, number of preamble 1-bits (>=14).

Ports:
- clk  input  1  system clock, same clock as the encoder prescaler.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  packet offered.
- pkt_ready  output  1  holding buffer empty; transfer occurs when pkt_valid & pkt_ready on a clk edge.
- pkt_data  input  8*MAX_BYTES  data bytes; byte 0 in bits [7:0] is sent first.
- pkt_len  input  3  number of valid data bytes, 2..MAX_BYTES.
- enc_ack  input  1  encoder ack level; high for several clk cycles per bit.
- next_bit  output  1  bit value the encoder samples for its next symbol.
- busy  output  1  a packet (not filler) is being transmitted.
- len_err  output  1  one-cycle pulse when a packet with illegal pkt_len is rejected.

Behaviour:
- Reset values: next_bit=1, pkt_ready=1, busy=0, len_err=0, state=FILL, buffer empty, ack_d=0. Reset mid-packet abandons the packet and clears the buffer.
- Advance event: adv = enc_ack & ~ack_d, where ack_d is enc_ack registered on clk. Exactly one bit step per ack pulse, regardless of its length in clk cycles. Output changes only on adv.
- Buffer handshake:
  - Accept when pkt_valid & pkt_ready: store data, len, and error byte = XOR of bytes 0..len-1. pkt_ready drops the next cycle.
  - pkt_len <2 or >MAX_BYTES: handshake completes, len_err pulses, buffer stays empty.
  - Buffer is released (pkt_ready=1 next cycle) when the sequencer loads it into the shift state.
  - Accept and load in the same cycle: load takes the old contents and the new packet fills the buffer.
- State machine (transitions on adv only):
  - FILL: next_bit=1. If buffer full -> PREAMBLE with pre_cnt=1, else stay.
  - PREAMBLE: next_bit=1, pre_cnt++. At pre_cnt==PREAMBLE_BITS -> SEP, load the buffer into the shift regs, byte_idx=0.
  - SEP: next_bit=0 -> DATA, bit_idx=7.
  - DATA: next_bit=cur_byte[bit_idx]. bit_idx 0 -> SEP if more bytes remain (the error byte counts as the last byte), else END.
  - END: next_bit=1. If buffer full -> PREAMBLE, counting the end bit as preamble bit 1; else -> FILL.
- busy=1 in PREAMBLE..END.
- Total bits per packet = PREAMBLE_BITS + 9*(len+1) + 1.
- byte_idx is 3 bits, bit_idx 3 bits, pre_cnt $clog2(PREAMBLE_BITS+1) bits. The error byte is computed combinationally at accept and registered; no wider arithmetic.

Optional Feature:
- Macro: DCC_IDLE_PACKET_EN.
- Defined: while FILL would otherwise be entered with the buffer empty, the sequencer transmits the DCC idle packet internally instead. The idle packet is bytes 0xFF, 0x00, with error byte 0xFF, using the full preamble and busy=0.
  - A user packet arriving mid-idle-packet waits until the idle packet's END.
- Not defined: filler is a continuous stream of 1 bits in FILL.

Decomposition:
- Shared package dcc_pkg holds:
  - state enum (FILL, PREAMBLE, SEP, DATA, END);
  - DCC_IDLE_ADDR=8'hFF, DCC_IDLE_DATA=8'h00;
  - DCC_MIN_PREAMBLE=14, DCC_MIN_BYTES=2.
- One natural sub-module, dcc_pkt_buffer: the one-entry holding register with length check and XOR error-byte generation.

Test Plan:
- Reset, no packets, macro off, 40 ack pulses -> next_bit constant 1, busy=0, pkt_ready=1.
- Send packet {0x03,0x3F}, len=2 -> after 14 ones: 0, 00000011, 0, 00111111, 0, 00111100 (error byte 0x3C), then 1; 42 bits total; busy high for exactly those steps.
- Queue a second packet during the first packet's DATA -> pkt_ready low until the load. END bit is followed by 13 further ones, then the start bit; no FILL gap.
- enc_ack held high 10 clk cycles per pulse -> exactly one bit step per pulse; no double advance.
- pkt_len=1 and pkt_len=7 -> len_err single-cycle pulse, nothing transmitted, pkt_ready stays 1.
- Macro on, no packets -> repeating 14 ones, 0, 0xFF, 0, 0x00, 0, 0xFF, 1; busy=0. Assert reset mid-DATA -> next cycle next_bit=1, state FILL, buffer empty.

Source files
------------

// File: rtl/dcc_pkg.sv
// Shared types and constants for the DCC packet sequencer.
// Holds the FSM state enum, idle packet bytes and DCC protocol minimums.
package dcc_pkg;

    typedef enum logic [2:0] {
        FILL,
        PREAMBLE,
        SEP,
        DATA,
        END
    } state_t;

    localparam logic [7:0] DCC_IDLE_ADDR = 8'hFF;
    localparam logic [7:0] DCC_IDLE_DATA = 8'h00;

    localparam int DCC_MIN_PREAMBLE = 14;
    localparam int DCC_MIN_BYTES    = 2;

endpackage

// File: rtl/dcc_packet_sequencer_if.sv
// Packet handshake bundle between a packet source and the sequencer.
// Ports: pkt_valid, pkt_ready, pkt_data (byte 0 in [7:0]), pkt_len.
interface dcc_packet_sequencer_if #(
    parameter int MAX_BYTES = 5
);
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [8*MAX_BYTES-1:0] pkt_data;
    logic [2:0]             pkt_len;

    modport master (
        output pkt_valid,
        output pkt_data,
        output pkt_len,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_data,
        input  pkt_len,
        output pkt_ready
    );
endinterface

// File: rtl/dcc_pkt_buffer.sv
// One-entry packet holding register with length check and XOR error byte.
// Ports: clk, reset, pkt (slave), load (release), full, data, len, err, len_err.
module dcc_pkt_buffer
    import dcc_pkg::*;
#(
    parameter int MAX_BYTES = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    dcc_packet_sequencer_if.slave  pkt,
    input  logic                   load,
    output logic                   full,
    output logic [8*MAX_BYTES-1:0] data,
    output logic [2:0]             len,
    output logic [7:0]             err,
    output logic                   len_err
);

    logic       accept;
    logic       legal;
    logic [7:0] err_c;

    assign pkt.pkt_ready = ~full;
    assign accept = pkt.pkt_valid & ~full;
    assign legal  = (pkt.pkt_len >= 3'(DCC_MIN_BYTES)) &&
                    (pkt.pkt_len <= 3'(MAX_BYTES));

    always_comb begin
        err_c = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (3'(i) < pkt.pkt_len) begin
                err_c = err_c ^ pkt.pkt_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            len_err <= accept & ~legal;
            if (load) begin
                full <= 1'b0;
            end
            // a fresh accept wins over a same-cycle release
            if (accept & legal) begin
                full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept & legal) begin
            data <= pkt.pkt_data;
            len  <= pkt.pkt_len;
            err  <= err_c;
        end
    end

endmodule

// File: rtl/dcc_packet_sequencer.sv
// DCC bit scheduler: preamble, 0-separated MSB-first bytes, XOR byte, end bit.
// Ports: clk, reset, pkt (slave), enc_ack, next_bit, busy, len_err.
// Macro DCC_IDLE_PACKET_EN: send idle packets instead of a plain 1-bit filler.
module dcc_packet_sequencer
    import dcc_pkg::*;
#(
    parameter int MAX_BYTES     = 5,
    parameter int PREAMBLE_BITS = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    dcc_packet_sequencer_if.slave pkt,
    input  logic                  enc_ack,
    output logic                  next_bit,
    output logic                  busy,
    output logic                  len_err
);

    localparam int PRE = (PREAMBLE_BITS < DCC_MIN_PREAMBLE) ?
                         DCC_MIN_PREAMBLE : PREAMBLE_BITS;
    localparam int PW  = $clog2(PRE + 1);

    state_t                 state;
    logic                   ack_d;
    logic                   adv;
    logic                   idle;
    logic                   load;
    logic                   load_buf;
    logic                   buf_full;
    logic [8*MAX_BYTES-1:0] buf_data;
    logic [2:0]             buf_len;
    logic [7:0]             buf_err;
    logic [PW-1:0]          pre_cnt;
    logic [2:0]             byte_idx;
    logic [2:0]             bit_idx;
    logic [2:0]             last_idx;
    logic [7:0]             sh_bytes [MAX_BYTES+1];
    logic [7:0]             cur_byte;

    dcc_pkt_buffer #(
        .MAX_BYTES (MAX_BYTES)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .pkt     (pkt),
        .load    (load_buf),
        .full    (buf_full),
        .data    (buf_data),
        .len     (buf_len),
        .err     (buf_err),
        .len_err (len_err)
    );

    // one step per rising edge of the ack level
    assign adv      = enc_ack & ~ack_d;
    assign load     = adv && (state == PREAMBLE) && (pre_cnt == PW'(PRE));
    assign load_buf = load & ~idle;
    assign cur_byte = sh_bytes[byte_idx];

    always_ff @(posedge clk) begin
        if (load) begin
            if (idle) begin
                sh_bytes[0] <= DCC_IDLE_ADDR;
                sh_bytes[1] <= DCC_IDLE_DATA;
                sh_bytes[2] <= DCC_IDLE_ADDR ^ DCC_IDLE_DATA;
                last_idx    <= 3'd2;
            end else begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    sh_bytes[i] <= buf_data[8*i +: 8];
                end
                // error byte sits right after the last data byte
                sh_bytes[buf_len] <= buf_err;
                last_idx          <= buf_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            next_bit <= 1'b1;
            busy     <= 1'b0;
            idle     <= 1'b0;
            ack_d    <= 1'b0;
            pre_cnt  <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
        end else begin
            ack_d <= enc_ack;
            if (adv) begin
                unique case (state)
                    FILL: begin
                        next_bit <= 1'b1;
                        if (buf_full) begin
                            state   <= PREAMBLE;
                            pre_cnt <= PW'(1);
                            busy    <= 1'b1;
                            idle    <= 1'b0;
                        end
`ifdef DCC_IDLE_PACKET_EN
                        else begin
                            state   <= PREAMBLE;
                            pre_cnt <= PW'(1);
                            busy    <= 1'b0;
                            idle    <= 1'b1;
                        end
`endif
                    end
                    PREAMBLE: begin
                        next_bit <= 1'b1;
                        if (pre_cnt == PW'(PRE)) begin
                            state    <= SEP;
                            next_bit <= 1'b0;
                            byte_idx <= '0;
                        end else begin
                            pre_cnt <= pre_cnt + PW'(1);
                        end
                    end
                    SEP: begin
                        state    <= DATA;
                        bit_idx  <= 3'd7;
                        next_bit <= cur_byte[7];
                    end
                    DATA: begin
                        if (bit_idx != 3'd0) begin
                            bit_idx  <= bit_idx - 3'd1;
                            next_bit <= cur_byte[bit_idx - 3'd1];
                        end else if (byte_idx != last_idx) begin
                            state    <= SEP;
                            next_bit <= 1'b0;
                            byte_idx <= byte_idx + 3'd1;
                        end else begin
                            state    <= END;
                            next_bit <= 1'b1;
                        end
                    end
                    END: begin
                        next_bit <= 1'b1;
                        if (buf_full) begin
                            // end bit doubles as preamble bit 1
                            state   <= PREAMBLE;
                            pre_cnt <= PW'(2);
                            busy    <= 1'b1;
                            idle    <= 1'b0;
                        end
`ifdef DCC_IDLE_PACKET_EN
                        else begin
                            state   <= PREAMBLE;
                            pre_cnt <= PW'(1);
                            busy    <= 1'b0;
                            idle    <= 1'b1;
                        end
`else
                        else begin
                            state <= FILL;
                            busy  <= 1'b0;
                        end
`endif
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcc_packet_sequencer.sv
// Self-checking bench for dcc_packet_sequencer against a bit-stream model.
// Honours DCC_IDLE_PACKET_EN in its reference model.
module tb_dcc_packet_sequencer;

    localparam int MB = 5;
    localparam int PB = 14;

    typedef logic [8*MB-1:0] pdata_t;
    typedef struct {
        bit b;
        bit bz;
        bit rel;
        bit e;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic enc_ack;
    logic next_bit;
    logic busy;
    logic len_err;

    always #5 clk = ~clk;

    dcc_packet_sequencer_if #(.MAX_BYTES(MB)) pkt_if ();

    dcc_packet_sequencer #(
        .MAX_BYTES     (MB),
        .PREAMBLE_BITS (PB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pkt      (pkt_if),
        .enc_ack  (enc_ack),
        .next_bit (next_bit),
        .busy     (busy),
        .len_err  (len_err)
    );

    ent_t   exp_q [$];
    pdata_t pend_d [$];
    int     pend_l [$];
    bit     buf_m;
    bit     last_end;
    bit     exp_b;
    bit     exp_bz;
    int     n_tests;
    int     n_fail;

    // expected bit stream of one packet; rel marks the step that frees the buffer
    function automatic void push_pkt(pdata_t d, int len, int pre,
                                     bit bz, bit rel);
        logic [7:0] bytes [$];
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
            bytes.push_back(d[8*i +: 8]);
            x = x ^ d[8*i +: 8];
        end
        bytes.push_back(x);
        for (int i = 0; i < pre; i++)
            exp_q.push_back('{1'b1, bz, 1'b0, 1'b0});
        foreach (bytes[k]) begin
            exp_q.push_back('{1'b0, bz, rel && (k == 0), 1'b0});
            for (int j = 7; j >= 0; j--)
                exp_q.push_back('{bytes[k][j], bz, 1'b0, 1'b0});
        end
        exp_q.push_back('{1'b1, bz, 1'b0, 1'b1});
    endfunction

    function automatic void model_step();
        ent_t e;
        if (exp_q.size() == 0) begin
            if (pend_l.size() > 0) begin
                push_pkt(pend_d.pop_front(), pend_l.pop_front(),
                         last_end ? PB - 1 : PB, 1'b1, 1'b1);
            end else begin
`ifdef DCC_IDLE_PACKET_EN
                push_pkt(pdata_t'(16'h00FF), 2, PB, 1'b0, 1'b0);
`else
                exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
`endif
            end
        end
        e = exp_q.pop_front();
        last_end = e.e;
        if (e.rel) buf_m = 1'b0;
        exp_b  = e.b;
        exp_bz = e.bz;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pend_d.delete();
        pend_l.delete();
        buf_m    = 1'b0;
        last_end = 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enc_ack = 1'b0;
        pkt_if.pkt_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse(int w);
        @(negedge clk);
        enc_ack = 1'b1;
        repeat (w) @(negedge clk);
        enc_ack = 1'b0;
        @(negedge clk);
        model_step();
    endtask

    task automatic send(pdata_t d, logic [2:0] len);
        @(negedge clk);
        pkt_if.pkt_valid = 1'b1;
        pkt_if.pkt_data  = d;
        pkt_if.pkt_len   = len;
        @(negedge clk);
        pkt_if.pkt_valid = 1'b0;
        if (len >= 2 && len <= MB) begin
            pend_d.push_back(d);
            pend_l.push_back(int'(len));
            buf_m = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if (next_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_next_bit got %b exp 1", next_bit);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        n_tests++;
        if (pkt_if.pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 1", pkt_if.pkt_ready);
        end
        n_tests++;
        if (len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_len_err got %b exp 0", len_err);
        end
    endtask

    task automatic test_filler();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            pulse(1 + int'($urandom % 3));
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz) begin
                n_fail++;
                $display("FAIL filler step %0d got bit=%b busy=%b exp bit=%b busy=%b",
                         i, next_bit, busy, exp_b, exp_bz);
            end
            n_tests++;
            if (pkt_if.pkt_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL filler_ready step %0d got %b exp 1",
                         i, pkt_if.pkt_ready);
            end
        end
    endtask

    task automatic test_single_packet();
        logic [41:0] ref_bits;
        ref_bits = {14'h3FFF, 28'b0000000110001111110001111001};
        do_reset();
        send(pdata_t'(16'h3F03), 3'd2);
        n_tests++;
        if (pkt_if.pkt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_drop got %b exp 0", pkt_if.pkt_ready);
        end
        for (int i = 0; i < 42; i++) begin
            pulse((i % 4 == 0) ? 10 : 1 + int'($urandom % 3));
            n_tests++;
            if (next_bit !== ref_bits[41-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single step %0d got bit=%b busy=%b exp bit=%b busy=1",
                         i, next_bit, busy, ref_bits[41-i]);
            end
            n_tests++;
            if (pkt_if.pkt_ready !== (i >= 14)) begin
                n_fail++;
                $display("FAIL single_ready step %0d got %b exp %b",
                         i, pkt_if.pkt_ready, i >= 14);
            end
        end
        pulse(2);
        n_tests++;
        if (next_bit !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after got bit=%b busy=%b exp bit=1 busy=0",
                     next_bit, busy);
        end
    endtask

    task automatic test_back_to_back();
        int  steps;
        int  ones;
        bit  counting;
        bit  counted;
        do_reset();
        send(pdata_t'({$urandom, $urandom}), 3'($urandom_range(MB, 2)));
        for (int i = 0; i < 20; i++) begin
            pulse(1 + int'($urandom % 4));
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz ||
                pkt_if.pkt_ready !== !buf_m) begin
                n_fail++;
                $display("FAIL b2b_a step %0d got bit=%b busy=%b rdy=%b exp bit=%b busy=%b rdy=%b",
                         i, next_bit, busy, pkt_if.pkt_ready,
                         exp_b, exp_bz, !buf_m);
            end
        end
        send(pdata_t'({$urandom, $urandom}), 3'($urandom_range(MB, 2)));
        steps = 0;
        ones = 0;
        counting = 1'b0;
        counted = 1'b0;
        while ((exp_q.size() > 0 || pend_l.size() > 0) && steps < 300) begin
            pulse(1 + int'($urandom % 4));
            steps++;
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz ||
                pkt_if.pkt_ready !== !buf_m) begin
                n_fail++;
                $display("FAIL b2b step %0d got bit=%b busy=%b rdy=%b exp bit=%b busy=%b rdy=%b",
                         steps, next_bit, busy, pkt_if.pkt_ready,
                         exp_b, exp_bz, !buf_m);
            end
            if (counting && !counted) begin
                if (next_bit === 1'b1) ones++;
                else counted = 1'b1;
            end
            if (last_end && !counting) counting = 1'b1;
        end
        n_tests++;
        if (steps >= 300) begin
            n_fail++;
            $display("FAIL b2b_budget got %0d steps exp below 300", steps);
        end
        n_tests++;
        if (ones !== PB - 1) begin
            n_fail++;
            $display("FAIL b2b_gap_ones got %0d exp %0d", ones, PB - 1);
        end
    endtask

    task automatic test_long_ack();
        do_reset();
        send(pdata_t'({$urandom, $urandom}), 3'($urandom_range(MB, 2)));
        for (int i = 0; i < 50; i++) begin
            pulse(10);
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz) begin
                n_fail++;
                $display("FAIL long_ack step %0d got bit=%b busy=%b exp bit=%b busy=%b",
                         i, next_bit, busy, exp_b, exp_bz);
            end
        end
    endtask

    task automatic test_len_err();
        logic [2:0] bad [2];
        bad[0] = 3'd1;
        bad[1] = 3'd7;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send(pdata_t'({$urandom, $urandom}), bad[k]);
            n_tests++;
            if (len_err !== 1'b1) begin
                n_fail++;
                $display("FAIL len_err_pulse len=%0d got %b exp 1", bad[k], len_err);
            end
            n_tests++;
            if (pkt_if.pkt_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL len_err_ready len=%0d got %b exp 1",
                         bad[k], pkt_if.pkt_ready);
            end
            @(negedge clk);
            n_tests++;
            if (len_err !== 1'b0) begin
                n_fail++;
                $display("FAIL len_err_width len=%0d got %b exp 0", bad[k], len_err);
            end
        end
        for (int i = 0; i < 6; i++) begin
            pulse(2);
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz) begin
                n_fail++;
                $display("FAIL len_err_stream step %0d got bit=%b busy=%b exp bit=%b busy=%b",
                         i, next_bit, busy, exp_b, exp_bz);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(pdata_t'(16'h3F03), 3'd2);
        for (int i = 0; i < 17; i++) pulse(1);
        send(pdata_t'({$urandom, $urandom}), 3'd4);
        for (int i = 0; i < 3; i++) pulse(1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_tests++;
        if (next_bit !== 1'b1 || busy !== 1'b0 || pkt_if.pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got bit=%b busy=%b rdy=%b exp 1 0 1",
                     next_bit, busy, pkt_if.pkt_ready);
        end
        for (int i = 0; i < 30; i++) begin
            pulse(1 + int'($urandom % 3));
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz ||
                pkt_if.pkt_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_after step %0d got bit=%b busy=%b rdy=%b exp bit=%b busy=%b rdy=1",
                         i, next_bit, busy, pkt_if.pkt_ready, exp_b, exp_bz);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (!buf_m && ($urandom % 3 == 0))
                send(pdata_t'({$urandom, $urandom}), 3'($urandom_range(MB, 2)));
            pulse(1 + int'($urandom % 10));
            n_tests++;
            if (next_bit !== exp_b || busy !== exp_bz ||
                pkt_if.pkt_ready !== !buf_m) begin
                n_fail++;
                $display("FAIL random step %0d got bit=%b busy=%b rdy=%b exp bit=%b busy=%b rdy=%b",
                         i, next_bit, busy, pkt_if.pkt_ready,
                         exp_b, exp_bz, !buf_m);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        enc_ack = 1'b0;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_data = '0;
        pkt_if.pkt_len = 3'd0;
        model_reset();
        test_reset();
        test_filler();
        test_single_packet();
        test_back_to_back();
        test_long_ack();
        test_len_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
